// File: rtl/rs5_plic.sv
// rs5_plic: platform-level interrupt controller with up to 31 edge-triggered sources and a claim/complete handshake.
// Define RS5_PLIC_THRESHOLD_EN to implement the threshold register; otherwise the threshold is hardwired to 0.
module rs5_plic #(
    parameter int i_cnt = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [3:0]       we_i,
    input  logic [23:0]      addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    input  logic [i_cnt-1:0] irq_i,
    input  logic             iack_i,
    output logic [i_cnt-1:0] iack_o,
    output logic             irq_o
);

    localparam logic [21:0] W_PENDING = 22'h000400;
    localparam logic [21:0] W_ENABLE  = 22'h000800;
    localparam logic [21:0] W_THRESH  = 22'h080000;
    localparam logic [21:0] W_CLAIM   = 22'h080001;

    logic [21:0]      word;
    logic             wr_en;
    logic             rd_en;
    logic [2:0]       threshold;

    logic [i_cnt:1]   pending_q, pending_d;
    logic [i_cnt:1]   enable_q, enable_d;
    logic [i_cnt:1]   qual;
    logic [i_cnt-1:0] irq_prev_q, irq_prev_d;
    logic [i_cnt-1:0] iack_o_q, iack_o_d;
    logic [4:0]       claim_q, claim_d;
    logic [31:0]      data_o_q, data_o_d;
    logic             irq_o_q, irq_o_d;

    logic [4:0]       win_id_c   [0:i_cnt];
    logic [2:0]       win_prio_c [0:i_cnt];
    logic [2:0]       prio_rd_c  [0:i_cnt];
    logic [4:0]       win_id;
    logic             win_valid;
    logic             claim_fire;
    logic             complete;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign word        = addr_i[23:2];
    assign wr_en       = en_i && (we_i != 4'd0);
    assign rd_en       = en_i && (we_i == 4'd0);
    assign unused_bits = ^{addr_i[1:0], data_i};

`ifdef RS5_PLIC_THRESHOLD_EN
    logic [2:0] threshold_q, threshold_d;

    assign threshold_d = (wr_en && we_i[0] && (word == W_THRESH)) ? data_i[2:0] : threshold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            threshold_q <= '0;
        end else begin
            threshold_q <= threshold_d;
        end
    end

    assign threshold = threshold_q;
`else
    assign threshold = 3'd0;
`endif

    // Winner search is a ripple chain from ID 1 upward; a strictly greater priority is
    // required to displace the current candidate, so ties resolve to the lowest ID.
    assign win_id_c[0]   = '0;
    assign win_prio_c[0] = '0;
    assign prio_rd_c[0]  = '0;

    genvar gi;
    generate
        for (gi = 1; gi <= i_cnt; gi++) begin : g_src
            logic [2:0] prio_q, prio_d;
            logic       take;

            assign prio_d = (wr_en && we_i[0] && (word == 22'(gi))) ? data_i[2:0] : prio_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    prio_q <= '0;
                end else begin
                    prio_q <= prio_d;
                end
            end

            assign enable_d[gi] = (wr_en && we_i[gi/8] && (word == W_ENABLE)) ? data_i[gi] : enable_q[gi];
            assign qual[gi]     = pending_q[gi] && enable_q[gi] && (prio_q > threshold);

            assign take           = qual[gi] && ((win_id_c[gi-1] == 5'd0) || (prio_q > win_prio_c[gi-1]));
            assign win_id_c[gi]   = take ? 5'(gi) : win_id_c[gi-1];
            assign win_prio_c[gi] = take ? prio_q : win_prio_c[gi-1];
            assign prio_rd_c[gi]  = (word == 22'(gi)) ? prio_q : prio_rd_c[gi-1];

            // A claim of this source overrides any edge arriving in the same cycle.
            assign pending_d[gi] = (pending_q[gi] ||
                                    (irq_i[gi-1] && !irq_prev_q[gi-1] && (claim_q != 5'(gi))))
                                   && !(claim_fire && (win_id == 5'(gi)));
            assign iack_o_d[gi-1] = claim_fire && (win_id == 5'(gi));
        end
    endgenerate

    assign win_id     = win_id_c[i_cnt];
    assign win_valid  = (win_id != 5'd0);
    assign claim_fire = iack_i && (claim_q == 5'd0) && win_valid;
    assign complete   = wr_en && we_i[0] && (word == W_CLAIM) &&
                        (claim_q != 5'd0) && (data_i[4:0] == claim_q);
    assign irq_prev_d = irq_i;
    assign irq_o_d    = win_valid && (claim_q == 5'd0);

    always_comb begin
        claim_d = claim_q;
        if (complete) begin
            claim_d = '0;
        end
        if (claim_fire) begin
            claim_d = win_id;
        end
    end

    always_comb begin
        rdata = '0;
        case (word)
            W_PENDING: rdata[i_cnt:1] = pending_q;
            W_ENABLE:  rdata[i_cnt:1] = enable_q;
            W_THRESH:  rdata[2:0]     = threshold;
            W_CLAIM:   rdata[4:0]     = claim_q;
            default:   rdata[2:0]     = prio_rd_c[i_cnt];
        endcase
    end

    assign data_o_d = rd_en ? rdata : data_o_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            enable_q   <= '0;
            irq_prev_q <= '0;
            iack_o_q   <= '0;
            claim_q    <= '0;
            data_o_q   <= '0;
            irq_o_q    <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            irq_prev_q <= irq_prev_d;
            iack_o_q   <= iack_o_d;
            claim_q    <= claim_d;
            data_o_q   <= data_o_d;
            irq_o_q    <= irq_o_d;
        end
    end

    assign data_o = data_o_q;
    assign iack_o = iack_o_q;
    assign irq_o  = irq_o_q;

endmodule

// File: tb/tb_rs5_plic.sv
// Directed and random stimulus for rs5_plic (3 sources) against a behavioural model of the controller.
module tb_rs5_plic;
    localparam int N = 3;
`ifdef RS5_PLIC_THRESHOLD_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          en_i;
    logic [3:0]    we_i;
    logic [23:0]   addr_i;
    logic [31:0]   data_i;
    logic [31:0]   data_o;
    logic [N-1:0]  irq_i;
    logic          iack_i;
    logic [N-1:0]  iack_o;
    logic          irq_o;

    always #5 clk = ~clk;

    rs5_plic #(.i_cnt(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .en_i   (en_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .irq_i  (irq_i),
        .iack_i (iack_i),
        .iack_o (iack_o),
        .irq_o  (irq_o)
    );

    int errors = 0;
    int checks = 0;

    logic         rst_r = 1'b1;
    logic [N-1:0] irq_r = '0;

    // Reference state
    logic [2:0]   m_prio [1:N];
    logic [N:1]   m_pend;
    logic [N:1]   m_en;
    logic [2:0]   m_thr;
    int           m_claim;
    logic [N-1:0] m_prev;
    logic [31:0]  exp_data;
    logic         exp_irq;
    logic [N-1:0] exp_iack;

    logic [23:0]  addrs [10] = '{24'h0, 24'h4, 24'h8, 24'hC, 24'h10,
                                 24'h1000, 24'h2000, 24'h200000, 24'h200004, 24'h3000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_winner();
        for (int p = 7; p >= 1; p--) begin
            if (p > int'(m_thr)) begin
                for (int id = 1; id <= N; id++) begin
                    if (m_pend[id] && m_en[id] && int'(m_prio[id]) == p) return id;
                end
            end
        end
        return 0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 32; b++) begin
            if (we[b/8]) r[b] = d[b];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [23:0] a);
        int w;
        logic [31:0] r;
        w = int'(a) / 4;
        r = '0;
        if (w >= 1 && w <= N)  r = 32'(m_prio[w]);
        else if (w == 'h400)   r = 32'({m_pend, 1'b0});
        else if (w == 'h800)   r = 32'({m_en, 1'b0});
        else if (w == 'h80000) r = 32'(m_thr);
        else if (w == 'h80001) r = 32'(m_claim);
        return r;
    endfunction

    task automatic model_step(input logic rst, input logic en, input logic [3:0] we, input logic [23:0] a,
                              input logic [31:0] d, input logic iack, input logic [N-1:0] irq);
        int win;
        int w;
        int old_claim;
        logic [31:0] mg;
        if (rst) begin
            for (int id = 1; id <= N; id++) m_prio[id] = '0;
            m_pend = '0; m_en = '0; m_thr = '0; m_claim = 0; m_prev = '0;
            exp_data = '0; exp_irq = 1'b0; exp_iack = '0;
            return;
        end
        win       = m_winner();
        old_claim = m_claim;
        exp_irq   = (win != 0) && (m_claim == 0);
        exp_iack  = '0;
        if (en && we == 4'd0) exp_data = m_read(a);
        for (int id = 1; id <= N; id++) begin
            if (irq[id-1] && !m_prev[id-1] && id != old_claim) m_pend[id] = 1'b1;
        end
        m_prev = irq;
        if (en && we != 4'd0) begin
            w = int'(a) / 4;
            if (w >= 1 && w <= N) begin
                mg = merge(32'(m_prio[w]), d, we);
                m_prio[w] = mg[2:0];
            end else if (w == 'h800) begin
                mg = merge(32'({m_en, 1'b0}), d, we);
                m_en = mg[N:1];
            end else if (w == 'h80000 && THR_EN) begin
                mg = merge(32'(m_thr), d, we);
                m_thr = mg[2:0];
            end else if (w == 'h80001 && we[0] && old_claim != 0 && int'(d[4:0]) == old_claim) begin
                m_claim = 0;
            end
        end
        if (iack && old_claim == 0 && win != 0) begin
            m_claim = win;
            m_pend[win] = 1'b0;
            exp_iack[win-1] = 1'b1;
        end
    endtask

    task automatic step(input logic en, input logic [3:0] we, input logic [23:0] a,
                        input logic [31:0] d, input logic iack);
        reset = rst_r; en_i = en; we_i = we; addr_i = a; data_i = d; iack_i = iack; irq_i = irq_r;
        @(posedge clk);
        model_step(rst_r, en, we, a, d, iack, irq_r);
        #1;
        chk("data_o", data_o, exp_data);
        chk("irq_o", 32'(irq_o), 32'(exp_irq));
        chk("iack_o", 32'(iack_o), 32'(exp_iack));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'd0, 24'd0, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d);
        step(1'b1, 4'hF, a, d, 1'b0);
    endtask

    task automatic wrb(input logic [23:0] a, input logic [31:0] d, input logic [3:0] we);
        step(1'b1, we, a, d, 1'b0);
    endtask

    task automatic ack();
        step(1'b0, 4'd0, 24'd0, 32'd0, 1'b1);
    endtask

    task automatic rdchk(input string tag, input logic [23:0] a, input logic [31:0] exp);
        step(1'b1, 4'd0, a, 32'd0, 1'b0);
        chk(tag, data_o, exp);
    endtask

    initial begin
        logic [23:0] a;
        logic [31:0] d;
        logic [3:0]  we;
        logic        ia;
        int          r;

        rst_r = 1'b1;
        idle(2);
        chk("rst_irq_o", 32'(irq_o), 32'd0);
        chk("rst_iack_o", 32'(iack_o), 32'd0);
        rst_r = 1'b0;
        for (int i = 0; i < 10; i++) rdchk("rst_read", addrs[i], 32'd0);

        // Basic claim/complete on source 1
        wr(24'h4, 32'd3);
        wr(24'h2000, 32'h2);
        irq_r = 3'b001;
        idle(1);
        chk("irq_o_lag", 32'(irq_o), 32'd0);
        rdchk("pending_edge", 24'h1000, 32'h2);
        chk("irq_o_set", 32'(irq_o), 32'd1);
        ack();
        chk("iack_o_pulse", 32'(iack_o), 32'h1);
        idle(1);
        chk("iack_o_single", 32'(iack_o), 32'h0);
        chk("irq_o_drop", 32'(irq_o), 32'd0);
        rdchk("claim_read", 24'h200004, 32'd1);
        rdchk("pending_clr", 24'h1000, 32'h0);
        idle(2);
        rdchk("held_high", 24'h1000, 32'h0);
        irq_r = 3'b000; idle(1); irq_r = 3'b001; idle(1);
        rdchk("toggle_claimed", 24'h1000, 32'h0);
        wr(24'h200004, 32'd1);
        rdchk("claim_done", 24'h200004, 32'd0);
        irq_r = 3'b000; idle(1); irq_r = 3'b001; idle(1);
        rdchk("toggle_after", 24'h1000, 32'h2);
        ack(); wr(24'h200004, 32'd1); irq_r = 3'b000; idle(1);

        // Threshold
        wr(24'h4, 32'd2);
        wr(24'h200000, 32'd2);
        irq_r = 3'b001;
        idle(3);
        chk("thr_block", 32'(irq_o), THR_EN ? 32'd0 : 32'd1);
        rdchk("thr_read", 24'h200000, THR_EN ? 32'd2 : 32'd0);
        wr(24'h200000, 32'd1);
        idle(1);
        chk("thr_release", 32'(irq_o), 32'd1);
        ack(); wr(24'h200004, 32'd1); wr(24'h200000, 32'd0); irq_r = 3'b000; idle(1);

        // Tie-break: priorities {1:2, 2:5, 3:5}
        wr(24'h4, 32'd2); wr(24'h8, 32'd5); wr(24'hC, 32'd5);
        wr(24'h2000, 32'hE);
        irq_r = 3'b111;
        idle(1);
        ack();
        chk("tie_first", 32'(iack_o), 32'h2);
        rdchk("tie_claim2", 24'h200004, 32'd2);
        wr(24'h200004, 32'd2);
        ack();
        chk("tie_second", 32'(iack_o), 32'h4);
        rdchk("tie_claim3", 24'h200004, 32'd3);
        wr(24'h200004, 32'd3);
        ack();
        chk("tie_third", 32'(iack_o), 32'h1);
        rdchk("tie_claim1", 24'h200004, 32'd1);
        wr(24'h200004, 32'd1);
        ack();
        chk("iack_none", 32'(iack_o), 32'h0);
        rdchk("claim_none", 24'h200004, 32'd0);
        irq_r = 3'b000; idle(1);

        // Byte lanes
        rdchk("en_before", 24'h2000, 32'hE);
        wrb(24'h2000, 32'hFFFF_FFFF, 4'h2);
        rdchk("en_lane1", 24'h2000, 32'hE);
        wrb(24'h2000, 32'h0, 4'h1);
        rdchk("en_lane0", 24'h2000, 32'h0);
        wrb(24'h4, 32'hFFFF_FF00, 4'hE);
        rdchk("prio_lanes", 24'h4, 32'd2);

        // Complete and edge on the same ID in the same cycle
        wr(24'h2000, 32'h2);
        irq_r = 3'b001; idle(1);
        ack();
        irq_r = 3'b000; idle(1);
        irq_r = 3'b001;
        wr(24'h200004, 32'd1);
        rdchk("cmpl_edge_drop", 24'h1000, 32'h0);
        rdchk("cmpl_edge_claim", 24'h200004, 32'd0);
        irq_r = 3'b000; idle(1); irq_r = 3'b001; idle(1);
        ack();
        wr(24'h200004, 32'd2);
        rdchk("cmpl_mismatch", 24'h200004, 32'd1);
        wr(24'h200004, 32'd1);
        irq_r = 3'b000; idle(1);

        // Random traffic
        ia = 1'b0;
        for (int t = 0; t < 600; t++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) irq_r = N'($urandom);
            a = addrs[$urandom_range(0, 9)] | 24'($urandom_range(0, 3));
            d = $urandom;
            if (a[23:2] == 22'h80001) d[4:0] = 5'($urandom_range(0, N));
            we = 4'($urandom_range(1, 15));
            if (r < 3)      step(1'b1, we, a, d, ia);
            else if (r < 6) step(1'b1, 4'd0, a, 32'd0, ia);
            else            step(1'b0, 4'd0, 24'd0, 32'd0, ia);
            ia = ($urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a claim
        wr(24'h200000, 32'd0);
        wr(24'h4, 32'd3); wr(24'h2000, 32'h2);
        irq_r = 3'b000; idle(1); irq_r = 3'b001; idle(1);
        ack();
        rdchk("pre_rst_claim", 24'h200004, 32'd1);
        rst_r = 1'b1; irq_r = 3'b000;
        idle(1);
        chk("midrst_data", data_o, 32'd0);
        chk("midrst_irq", 32'(irq_o), 32'd0);
        rst_r = 1'b0;
        rdchk("midrst_claim", 24'h200004, 32'd0);
        rdchk("midrst_en", 24'h2000, 32'd0);
        rdchk("midrst_prio", 24'h4, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
